// File: rtl/cpu_pkg.sv
// Shared datapath constants and the memory-interface FSM state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ABORT  = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait-cycle counter; expired_o flags the enabled edge that brings the count to TIMEOUT.
module mem_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Combinational look-ahead so the FSM can leave ACCESS on the same edge the count hits TIMEOUT.
  assign expired_o = en_i && (count_q >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_interface_unit.sv
// MAR/MDR holding stage and request/acknowledge sequencer towards external memory.
module mem_interface_unit #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import cpu_pkg::*;

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              expired;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .clear_n   (clear_n),
    .clr_i     (state_q != ST_ACCESS),
    .en_i      ((state_q == ST_ACCESS) && !mem_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    mem_we_d  = mem_we_q;
    err_d     = err_q;
    mem_req_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Loads land in the same edge as a start, so the first request cycle already sees them.
        if (mar_in) mar_d = bus_in[ADDR_W-1:0];
        if (mdr_in) mdr_d = bus_in;
        if (rd_start && wr_start) begin
          err_d = 1'b1;
        end else if (rd_start || wr_start) begin
          state_d   = ST_ACCESS;
          mem_we_d  = wr_start;
          err_d     = 1'b0;
          mem_req_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          if (!mem_we_q) mdr_d = mem_rdata;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (expired) begin
          state_d = ST_ABORT;
          err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mdr_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit: reset, loads, read, write, timeout, collision, reset mid-read.
module tb_mem_interface_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              clear_n;
  logic [DATA_W-1:0] bus_in;
  logic              mar_in;
  logic              mdr_in;
  logic              rd_start;
  logic              wr_start;
  logic [DATA_W-1:0] mdr_out;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  mem_interface_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .bus_in    (bus_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mdr_out   (mdr_out),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards are sampled at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    step();
    step();
    checks++;
    if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req/we/busy/done/err=%b required 00000", {mem_req, mem_we, busy, done, err});
    end
    checks++;
    if (mdr_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mdr: got %h required 00000000", mdr_out);
    end
    checks++;
    if (mem_addr !== 9'h0) begin
      errors++;
      $display("FAIL reset_mar: got %h required 000", mem_addr);
    end
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    bus_in = 32'h0000_01A5;
    mar_in = 1'b1;
    step();
    mar_in = 1'b0;
    checks++;
    if (mem_addr !== 9'h1A5) begin
      errors++;
      $display("FAIL load_mar: got %h required 1a5", mem_addr);
    end
    bus_in = 32'hDEAD_BEEF;
    mdr_in = 1'b1;
    step();
    mdr_in = 1'b0;
    checks++;
    if (mdr_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_mdr: got %h required deadbeef", mdr_out);
    end
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_idle: got busy=%b req=%b required 0 0", busy, mem_req);
    end
  endtask

  task automatic test_read();
    int req_cnt  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int we_seen  = 0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) req_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mem_req && mem_we) we_seen++;
      mem_ack   = mem_req && (req_cnt == 3);
      mem_rdata = 32'h1234_5678;
      step();
    end
    mem_ack = 1'b0;
    checks++;
    if (req_cnt !== 3) begin
      errors++;
      $display("FAIL read_req_cycles: got %0d required 3", req_cnt);
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++;
      $display("FAIL read_busy_cycles: got %0d required 4", busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL read_done_cycles: got %0d required 1", done_cnt);
    end
    checks++;
    if (we_seen !== 0) begin
      errors++;
      $display("FAIL read_we: got %0d write cycles required 0", we_seen);
    end
    checks++;
    if (mdr_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_mdr: got %h required 12345678", mdr_out);
    end
  endtask

  task automatic test_write();
    bus_in = 32'h0000_0003;
    mar_in = 1'b1;
    step();
    mar_in   = 1'b0;
    bus_in   = 32'hCAFE_F00D;
    mdr_in   = 1'b1;
    wr_start = 1'b1;
    step();
    mdr_in   = 1'b0;
    wr_start = 1'b0;
    bus_in   = 32'h0;
    checks++;
    if ({mem_req, mem_we, busy, done} !== 4'b1110) begin
      errors++;
      $display("FAIL write_req: got req/we/busy/done=%b required 1110", {mem_req, mem_we, busy, done});
    end
    checks++;
    if (mem_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL write_wdata: got %h required cafef00d", mem_wdata);
    end
    checks++;
    if (mem_addr !== 9'h003) begin
      errors++;
      $display("FAIL write_addr: got %h required 003", mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, done, busy} !== 3'b011) begin
      errors++;
      $display("FAIL write_done: got req/done/busy=%b required 011", {mem_req, done, busy});
    end
    checks++;
    if (mdr_out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL write_mdr_kept: got %h required cafef00d", mdr_out);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL write_idle: got busy/done=%b required 00", {busy, done});
    end
  endtask

  task automatic test_timeout();
    int req_cnt   = 0;
    int busy_cnt  = 0;
    int done_cnt  = 0;
    int abort_err = 0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (mem_req) req_cnt++;
      if (done) done_cnt++;
      if (!mem_req && err) abort_err++;
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_bound: got busy=%b after 40 cycles required 0", busy);
    end
    checks++;
    if (req_cnt !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_req_cycles: got %0d required %0d", req_cnt, TIMEOUT);
    end
    checks++;
    if (busy_cnt !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_busy_cycles: got %0d required %0d", busy_cnt, TIMEOUT + 1);
    end
    checks++;
    if (abort_err !== 1 || done_cnt !== 0) begin
      errors++;
      $display("FAIL timeout_abort: got abort_err_cycles=%0d done_cycles=%0d required 1 0", abort_err, done_cnt);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_sticky: got %b required 1", err);
    end
    checks++;
    if (mdr_out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL timeout_mdr: got %h required cafef00d", mdr_out);
    end
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    checks++;
    if ({err, mem_req} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_restart: got err/req=%b required 01", {err, mem_req});
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0;
    step();
    checks++;
    if (mdr_out !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL timeout_reread: got %h required 0badf00d", mdr_out);
    end
  endtask

  task automatic test_collision();
    rd_start = 1'b1;
    wr_start = 1'b1;
    step();
    rd_start = 1'b0;
    wr_start = 1'b0;
    checks++;
    if ({err, mem_req, busy} !== 3'b100) begin
      errors++;
      $display("FAIL collision: got err/req/busy=%b required 100", {err, mem_req, busy});
    end
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    bus_in   = 32'hFFFF_FFFF;
    mdr_in   = 1'b1;
    mar_in   = 1'b1;
    step();
    mdr_in = 1'b0;
    mar_in = 1'b0;
    checks++;
    if (mdr_out !== 32'h0BAD_F00D || mem_addr !== 9'h003) begin
      errors++;
      $display("FAIL busy_load_blocked: got mdr=%h mar=%h required 0badf00d 003", mdr_out, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    step();
    mem_ack = 1'b0;
    step();
    checks++;
    if (mdr_out !== 32'h55AA_55AA || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_read_after: got mdr=%h busy=%b required 55aa55aa 0", mdr_out, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int done_cnt = 0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    checks++;
    if ({mem_req, busy, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_ctrl: got req/busy/done/err=%b required 0000", {mem_req, busy, done, err});
    end
    checks++;
    if (mdr_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_mdr: got %h required 00000000", mdr_out);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || busy) done_cnt++;
    end
    mem_ack = 1'b0;
    checks++;
    if (done_cnt !== 0 || mdr_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_stray_ack: got activity=%0d mdr=%h required 0 00000000", done_cnt, mdr_out);
    end
  endtask

  initial begin
    clear_n   = 1'b0;
    bus_in    = '0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    rd_start  = 1'b0;
    wr_start  = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_load();
    test_read();
    test_write();
    test_timeout();
    test_collision();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
